sync_debounce_edge: RTL and testbench
=====================================

// Module: sync_debounce_edge
// PURPOSE
//   Front-end conditioning stage feeding the flop/register stages: takes an asynchronous,
//   possibly bouncing single-bit input and synchronises it into the clk domain. Filters
//   glitches shorter than DEBOUNCE_CYCLES sample edges. Produces a clean level q and
//   single-cycle rise/fall pulses for downstream registered logic.
// PARAMETERS
//   SYNC_STAGES      2   flops in synchroniser chain; legal range >= 2
//   DEBOUNCE_CYCLES  8   consecutive enabled samples that must differ from q before q flips; >= 1
//   RESET_VAL        1'b0 reset value of synchroniser flops and q
// PORTS
//   clk      input   1  clock, all state updates on posedge
//   resetn   input   1  reset, asynchronous, active-low
//   d_async  input   1  raw asynchronous input (may bounce)
//   en       input   1  sample enable; FSM and counter advance only on posedges with en=1
//   q        output  1  debounced, synchronised level
//   rise     output  1  1-cycle pulse when q changes 0->1
//   fall     output  1  1-cycle pulse when q changes 1->0
//   busy     output  1  1 while a candidate change is being qualified (state CHECK)
// BEHAVIOUR
//   Reset (async assert, any time incl. mid-CHECK), effective immediately:
//     sync flops=RESET_VAL, q=RESET_VAL, state=STABLE, cnt=0, rise=fall=busy=0.
//   Synchroniser: s[0]<=d_async, s[i]<=s[i-1] every posedge regardless of en; sync_out=s[SYNC_STAGES-1].
//   Counter cnt: width $clog2(DEBOUNCE_CYCLES+1); never wraps; saturates by state exit.
//   FSM, evaluated only on posedges with en=1 (en=0: state, cnt, q held; rise/fall=0):
//     STABLE: sync_out==q -> stay. sync_out!=q -> if DEBOUNCE_CYCLES==1 flip q now,
//             else CHECK with cnt=1.
//     CHECK : sync_out==q -> STABLE, cnt=0, q unchanged, no pulse (glitch rejected).
//             sync_out!=q and cnt==DEBOUNCE_CYCLES-1 -> q<=sync_out, pulse, STABLE, cnt=0.
//             else cnt<=cnt+1.
//   Latency (en=1 throughout, SYNC_STAGES=2): d_async stable from before posedge N
//     -> q changes at posedge N+SYNC_STAGES+DEBOUNCE_CYCLES-1 (N+9 with defaults).
//   Pulses are registered: rise/fall asserted for exactly the clk cycle following the edge
//     where q flips; rise=q_new&~q_old, fall=~q_new&q_old; never both high.
//   busy==(state==CHECK), registered.
//   Glitch of < DEBOUNCE_CYCLES enabled samples never reaches q. Input toggling back
//     mid-CHECK restarts qualification from STABLE; no partial-count carryover.
//   Reset release with d_async!=RESET_VAL: normal qualification, then one pulse.
//   Reset release with d_async==RESET_VAL: no pulse ever generated.
//   Reset asserted during CHECK or same cycle as a pulse: pulse suppressed, q=RESET_VAL.
// STRUCTURE
//   sync_debounce_pkg: typedef enum logic {ST_STABLE, ST_CHECK} db_state_e;
//     function cnt_width(int n) returning $clog2(n+1).
//   Sub-module sync_chain #(STAGES, RESET_VAL): N-flop synchroniser, async active-low reset.
//   Top: sync_chain instance + FSM/counter always_ff + pulse/busy registers.
//   Assertions (bound in bench): $onehot0({rise,fall}); rise|->q; fall|->!q;
//     q changes only on posedge with en=1; ~resetn |-> q==RESET_VAL.
// TESTING (clk period 20, defaults unless noted)
//   1 Reset: resetn=0 for 5 cycles with d_async toggling -> q=0, rise=fall=busy=0 throughout.
//   2 Clean step: d_async 0->1 before posedge N, en=1 -> q=1 at N+9, rise=1 one cycle, busy N+2..N+8.
//   3 Glitch: d_async=1 for 4 cycles then 0 -> q stays 0, no pulses, busy drops after glitch.
//   4 Enable gating: en=1 every 2nd cycle, step at N -> q flips only after 8 enabled samples.
//   5 Reset mid-CHECK: step at N, resetn=0 at N+5 -> q=0, busy=0 at once; release with
//     d_async=1 -> q=1 after 9 edges, one rise.
//   6 DEBOUNCE_CYCLES=1: step at N -> q flips at N+2, busy never asserted; fall on return to 0.

Source files
------------

// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared FSM state type and counter sizing helper for the debouncer
package sync_debounce_pkg;

    typedef enum logic {ST_STABLE, ST_CHECK} db_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser bringing an asynchronous bit into the clk domain
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] s;

    // shift the raw input through the chain every clock, independent of any enable
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) s <= {STAGES{RESET_VAL}};
        else         s <= {s[STAGES-2:0], d};

    assign q = s[STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: synchronise, debounce and edge-detect an asynchronous bouncing input
module sync_debounce_edge
    import sync_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_async,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int          CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_out;
    logic [CW-1:0] cnt;
    db_state_e     state;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (d_async),
        .q      (sync_out)
    );

    // qualify a candidate change for DEBOUNCE_CYCLES enabled samples; pulses and busy registered alongside q
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= ST_STABLE;
            cnt   <= '0;
            q     <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                if (sync_out == q) begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (DEBOUNCE_CYCLES == 1 || (state == ST_CHECK && cnt == LAST)) begin
                    q     <= sync_out;
                    rise  <= sync_out;
                    fall  <= !sync_out;
                    state <= ST_STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (state == ST_STABLE) begin
                    state <= ST_CHECK;
                    cnt   <= CW'(1);
                    busy  <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: scoreboard bench for the debouncer, default and single-cycle instances
module tb_sync_debounce_edge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic d_async = 1'b0;
    logic en = 1'b1;
    logic d_b = 1'b0;
    logic q_a, rise_a, fall_a, busy_a;
    logic q_b, rise_b, fall_b, busy_b;

    int compared = 0;
    int mismatched = 0;
    int ncyc = 0;

    typedef struct {
        bit r;
        int cyc;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    sync_debounce_edge dut_a (
        .clk     (clk),
        .resetn  (resetn),
        .d_async (d_async),
        .en      (en),
        .q       (q_a),
        .rise    (rise_a),
        .fall    (fall_a),
        .busy    (busy_a)
    );

    sync_debounce_edge #(.DEBOUNCE_CYCLES(1)) dut_b (
        .clk     (clk),
        .resetn  (resetn),
        .d_async (d_b),
        .en      (1'b1),
        .q       (q_b),
        .rise    (rise_b),
        .fall    (fall_b),
        .busy    (busy_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    a_onehot: assert property (@(posedge clk) $onehot0({rise_a, fall_a}));
    a_rise:   assert property (@(posedge clk) rise_a |-> q_a);
    a_fall:   assert property (@(posedge clk) fall_a |-> !q_a);
    a_en:     assert property (@(posedge clk) disable iff (!resetn) (q_a != $past(q_a)) |-> $past(en));
    a_rst:    assert property (@(posedge clk) !resetn |-> q_a == 1'b0);

    // pop the expected pulse whenever either instance emits one
    always @(negedge clk) begin
        ev_t e;
        if (rise_a || fall_a) begin
            compared++;
            if (qa.size() == 0) begin
                mismatched++;
                $display("FAIL pulse_a unexpected cyc=%0d rise=%b fall=%b", ncyc, rise_a, fall_a);
            end else begin
                e = qa.pop_front();
                if (e.r !== rise_a || e.r === fall_a || e.cyc != ncyc) begin
                    mismatched++;
                    $display("FAIL pulse_a got rise=%b fall=%b cyc=%0d want rise=%b cyc=%0d",
                             rise_a, fall_a, ncyc, e.r, e.cyc);
                end
            end
        end
        if (rise_b || fall_b) begin
            compared++;
            if (qb.size() == 0) begin
                mismatched++;
                $display("FAIL pulse_b unexpected cyc=%0d rise=%b fall=%b", ncyc, rise_b, fall_b);
            end else begin
                e = qb.pop_front();
                if (e.r !== rise_b || e.r === fall_b || e.cyc != ncyc) begin
                    mismatched++;
                    $display("FAIL pulse_b got rise=%b fall=%b cyc=%0d want rise=%b cyc=%0d",
                             rise_b, fall_b, ncyc, e.r, e.cyc);
                end
            end
        end
    end

    task automatic release_a();
        int c;
        @(negedge clk);
        d_async = 1'b0;
        c = ncyc;
        qa.push_back('{1'b0, c + 10});
        repeat (12) @(negedge clk);
        compared++;
        if (q_a !== 1'b0) begin
            mismatched++;
            $display("FAIL release_a q got %b want 0", q_a);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            compared++;
            if ({q_a, rise_a, fall_a, busy_a, q_b, rise_b, fall_b, busy_b} !== 8'b0) begin
                mismatched++;
                $display("FAIL reset_outputs k=%0d got %b want 00000000", k,
                         {q_a, rise_a, fall_a, busy_a, q_b, rise_b, fall_b, busy_b});
            end
            d_async = ~d_async;
            d_b = ~d_b;
        end
        @(negedge clk);
        d_async = 1'b0;
        d_b = 1'b0;
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        compared++;
        if ({q_a, busy_a, q_b, busy_b} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_idle got %b want 0000", {q_a, busy_a, q_b, busy_b});
        end
    endtask

    task automatic test_clean_step();
        int c;
        @(negedge clk);
        d_async = 1'b1;
        c = ncyc;
        qa.push_back('{1'b1, c + 10});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            compared++;
            if (busy_a !== logic'(k >= 3 && k <= 9)) begin
                mismatched++;
                $display("FAIL step_busy k=%0d got %b want %b", k, busy_a, k >= 3 && k <= 9);
            end
            compared++;
            if (q_a !== logic'(k >= 10)) begin
                mismatched++;
                $display("FAIL step_q k=%0d got %b want %b", k, q_a, k >= 10);
            end
        end
        release_a();
    endtask

    task automatic test_glitch();
        int lens[2] = '{4, 7};
        foreach (lens[i]) begin
            @(negedge clk);
            d_async = 1'b1;
            repeat (lens[i]) @(negedge clk);
            d_async = 1'b0;
            for (int j = 1; j <= 12; j++) begin
                @(negedge clk);
                compared++;
                if (q_a !== 1'b0) begin
                    mismatched++;
                    $display("FAIL glitch_q len=%0d j=%0d got %b want 0", lens[i], j, q_a);
                end
                if (j >= 2) begin
                    compared++;
                    if (busy_a !== logic'(j == 2)) begin
                        mismatched++;
                        $display("FAIL glitch_busy len=%0d j=%0d got %b want %b", lens[i], j, busy_a, j == 2);
                    end
                end
            end
        end
    endtask

    task automatic test_enable();
        int c;
        int n = 0;
        int flipj = 0;
        for (int j = 0; j < 40 && n < 8; j++) begin
            if (j % 2 == 0 && j >= 2) n++;
            if (n == 8) flipj = j;
        end
        @(negedge clk);
        d_async = 1'b1;
        en = 1'b1;
        c = ncyc;
        qa.push_back('{1'b1, c + flipj + 1});
        for (int j = 0; j <= flipj + 3; j++) begin
            @(negedge clk);
            compared++;
            if (q_a !== logic'(j >= flipj)) begin
                mismatched++;
                $display("FAIL enable_q j=%0d got %b want %b", j, q_a, j >= flipj);
            end
            en = logic'((j + 1) % 2 == 0);
        end
        en = 1'b1;
        release_a();
    endtask

    task automatic test_reset_mid_check();
        int c;
        @(negedge clk);
        d_async = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if (busy_a !== 1'b1) begin
            mismatched++;
            $display("FAIL midchk_busy_before got %b want 1", busy_a);
        end
        resetn = 1'b0;
        #1;
        compared++;
        if ({q_a, busy_a, rise_a} !== 3'b000) begin
            mismatched++;
            $display("FAIL midchk_reset got %b want 000", {q_a, busy_a, rise_a});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        c = ncyc;
        qa.push_back('{1'b1, c + 10});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            compared++;
            if (q_a !== logic'(k >= 10)) begin
                mismatched++;
                $display("FAIL midchk_q k=%0d got %b want %b", k, q_a, k >= 10);
            end
        end
        release_a();
    endtask

    task automatic test_db1();
        int c;
        for (int v = 1; v >= 0; v--) begin
            @(negedge clk);
            d_b = logic'(v);
            c = ncyc;
            qb.push_back('{bit'(v), c + 3});
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                compared++;
                if (busy_b !== 1'b0) begin
                    mismatched++;
                    $display("FAIL db1_busy v=%0d k=%0d got %b want 0", v, k, busy_b);
                end
                compared++;
                if (q_b !== logic'(k >= 3 ? v == 1 : v == 0)) begin
                    mismatched++;
                    $display("FAIL db1_q v=%0d k=%0d got %b want %b", v, k, q_b, k >= 3 ? v == 1 : v == 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_enable();
        test_reset_mid_check();
        test_db1();
        repeat (3) @(negedge clk);
        compared++;
        if (qa.size() != 0 || qb.size() != 0) begin
            mismatched++;
            $display("FAIL missing_pulses got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
